// File: rtl/sd_cmd_seq.sv
// sd_cmd_seq: SPI-mode SD-card command sequencer.
// Powers the card up, runs CMD0 / CMD8 / CMD55+ACMD41 initialisation, then
// serves single-block reads (CMD17), streaming the 512 data bytes out.
// Ports:
//   clk, reset (sync, active-low)
//   rd_req / rd_addr      block read request and SDHC block address
//   ready / init_done     idle-and-usable / sticky init-complete flag
//   error / err_code      sticky error and its cause (1..5)
//   rd_data / rd_valid / rd_last   block data stream
//   spi_start / spi_tx    byte request to the SPI master
//   spi_rx / spi_done / spi_busy   byte result and status from the SPI master
//   sd_cs                 card chip-select, active-low, held across a command
module sd_cmd_seq #(
  parameter int unsigned INIT_BYTES    = 10,
  parameter int unsigned RESP_TIMEOUT  = 8,
  parameter int unsigned TOKEN_TIMEOUT = 1024,
  parameter int unsigned INIT_RETRIES  = 1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rd_req,
  input  logic [31:0] rd_addr,
  output logic        ready,
  output logic        init_done,
  output logic        error,
  output logic [2:0]  err_code,
  output logic [7:0]  rd_data,
  output logic        rd_valid,
  output logic        rd_last,
  output logic        spi_start,
  output logic [7:0]  spi_tx,
  input  logic [7:0]  spi_rx,
  input  logic        spi_done,
  input  logic        spi_busy,
  output logic        sd_cs
);

  localparam int unsigned CNT_MAX_RI = (RESP_TIMEOUT > INIT_BYTES) ? RESP_TIMEOUT : INIT_BYTES;
  localparam int unsigned CNT_MAX    = (TOKEN_TIMEOUT > CNT_MAX_RI) ? TOKEN_TIMEOUT : CNT_MAX_RI;
  localparam int unsigned CNT_W      = $clog2(CNT_MAX + 1) < 3 ? 3 : $clog2(CNT_MAX + 1);
  localparam int unsigned RTY_W      = $clog2(INIT_RETRIES + 1);
  localparam int unsigned DCNT_W     = 10;

  typedef enum logic [3:0] {
    ST_PWRUP, ST_CMD, ST_FRAME, ST_R1, ST_R7, ST_GAP,
    ST_IDLE, ST_TOKEN, ST_DATA, ST_CRC, ST_ERROR
  } state_t;

  typedef enum logic [2:0] {C_CMD0, C_CMD8, C_CMD55, C_CMD41, C_CMD17} cmd_t;

  state_t              state;
  cmd_t                cmd_sel;
  logic                want;      // a byte is queued in spi_tx, start not yet issued
  logic                xfer;      // a byte is in flight in the SPI master
  logic                gap_idle;  // after the post-command 0xFF, go idle instead of next command
  logic [CNT_W-1:0]    cnt;
  logic [CNT_W-1:0]    cnt_nxt;
  logic [RTY_W-1:0]    rty_cnt;
  logic [RTY_W-1:0]    rty_nxt;
  logic [DCNT_W-1:0]   data_cnt;
  logic [31:0]         addr_q;
  logic                done_ev;

  logic [5:0]          cmd_idx;
  logic [31:0]         cmd_arg;
  logic [7:0]          cmd_crc;

  assign cnt_nxt = cnt + CNT_W'(1);
  assign rty_nxt = rty_cnt + RTY_W'(1);
  assign done_ev = xfer & spi_done;

  // Frame fields of the selected command.
  always_comb begin
    cmd_idx = 6'd0;
    cmd_arg = 32'h0000_0000;
    cmd_crc = 8'h01;
    case (cmd_sel)
      C_CMD0:  cmd_crc = 8'h95;
      C_CMD8:  begin cmd_idx = 6'd8;  cmd_arg = 32'h0000_01AA; cmd_crc = 8'h87; end
      C_CMD55: cmd_idx = 6'd55;
      C_CMD41: begin cmd_idx = 6'd41; cmd_arg = 32'h4000_0000; end
      C_CMD17: begin cmd_idx = 6'd17; cmd_arg = addr_q; end
      default: ;
    endcase
  end

  function automatic logic [7:0] frame_byte(input logic [2:0] k, input logic [5:0] idx,
                                            input logic [31:0] arg, input logic [7:0] crc);
    case (k)
      3'd0:    frame_byte = {2'b01, idx};
      3'd1:    frame_byte = arg[31:24];
      3'd2:    frame_byte = arg[23:16];
      3'd3:    frame_byte = arg[15:8];
      3'd4:    frame_byte = arg[7:0];
      3'd5:    frame_byte = crc;
      default: frame_byte = 8'hFF;
    endcase
  endfunction

  // Error code for a bad or missing R1, by command.
  function automatic logic [2:0] r1_err(input cmd_t c);
    case (c)
      C_CMD0:  r1_err = 3'd1;
      C_CMD8:  r1_err = 3'd2;
      C_CMD17: r1_err = 3'd4;
      default: r1_err = 3'd3;
    endcase
  endfunction

  // Sequencer: one byte at a time; every decision is taken on spi_done and the
  // resulting start is issued from 'want' on a later cycle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= ST_PWRUP;
      cmd_sel   <= C_CMD0;
      want      <= 1'b1;
      xfer      <= 1'b0;
      gap_idle  <= 1'b0;
      cnt       <= '0;
      rty_cnt   <= '0;
      data_cnt  <= '0;
      addr_q    <= 32'h0;
      ready     <= 1'b0;
      init_done <= 1'b0;
      error     <= 1'b0;
      err_code  <= 3'd0;
      rd_data   <= 8'h00;
      rd_valid  <= 1'b0;
      rd_last   <= 1'b0;
      spi_start <= 1'b0;
      spi_tx    <= 8'hFF;
      sd_cs     <= 1'b1;
    end else begin
      spi_start <= 1'b0;
      rd_valid  <= 1'b0;
      rd_last   <= 1'b0;

      if (want && !xfer && !spi_busy) begin
        spi_start <= 1'b1;
        xfer      <= 1'b1;
        want      <= 1'b0;
      end
      if (done_ev) xfer <= 1'b0;

      case (state)
        ST_PWRUP: if (done_ev) begin
          if (cnt_nxt == CNT_W'(INIT_BYTES)) begin
            state   <= ST_CMD;
            cmd_sel <= C_CMD0;
          end else begin
            cnt  <= cnt_nxt;
            want <= 1'b1;
          end
        end

        // Drop chip-select and queue the first frame byte.
        ST_CMD: begin
          sd_cs  <= 1'b0;
          spi_tx <= frame_byte(3'd0, cmd_idx, cmd_arg, cmd_crc);
          want   <= 1'b1;
          cnt    <= '0;
          state  <= ST_FRAME;
        end

        ST_FRAME: if (done_ev) begin
          want <= 1'b1;
          if (cnt_nxt == CNT_W'(6)) begin
            spi_tx <= 8'hFF;
            cnt    <= '0;
            state  <= ST_R1;
          end else begin
            spi_tx <= frame_byte(cnt_nxt[2:0], cmd_idx, cmd_arg, cmd_crc);
            cnt    <= cnt_nxt;
          end
        end

        // Poll for R1; a valid response on the last allowed poll still counts.
        ST_R1: if (done_ev) begin
          if (!spi_rx[7]) begin
            case (cmd_sel)
              C_CMD0: if (spi_rx == 8'h01) begin
                sd_cs <= 1'b1; spi_tx <= 8'hFF; want <= 1'b1;
                state <= ST_GAP; gap_idle <= 1'b0; cmd_sel <= C_CMD8;
              end else begin
                state <= ST_ERROR; error <= 1'b1; err_code <= 3'd1; sd_cs <= 1'b1;
              end
              C_CMD8: if (spi_rx == 8'h01) begin
                spi_tx <= 8'hFF; want <= 1'b1; cnt <= '0; state <= ST_R7;
              end else begin
                state <= ST_ERROR; error <= 1'b1; err_code <= 3'd2; sd_cs <= 1'b1;
              end
              C_CMD55: if (spi_rx[7:1] == 7'd0) begin
                sd_cs <= 1'b1; spi_tx <= 8'hFF; want <= 1'b1;
                state <= ST_GAP; gap_idle <= 1'b0; cmd_sel <= C_CMD41;
              end else begin
                state <= ST_ERROR; error <= 1'b1; err_code <= 3'd3; sd_cs <= 1'b1;
              end
              C_CMD41: if (spi_rx == 8'h00) begin
                init_done <= 1'b1;
                sd_cs <= 1'b1; spi_tx <= 8'hFF; want <= 1'b1;
                state <= ST_GAP; gap_idle <= 1'b1;
              end else if (spi_rx == 8'h01 && rty_nxt != RTY_W'(INIT_RETRIES)) begin
                rty_cnt <= rty_nxt;
                sd_cs <= 1'b1; spi_tx <= 8'hFF; want <= 1'b1;
                state <= ST_GAP; gap_idle <= 1'b0; cmd_sel <= C_CMD55;
              end else begin
                state <= ST_ERROR; error <= 1'b1; err_code <= 3'd3; sd_cs <= 1'b1;
              end
              default: if (spi_rx == 8'h00) begin
                spi_tx <= 8'hFF; want <= 1'b1; cnt <= '0; state <= ST_TOKEN;
              end else begin
                state <= ST_ERROR; error <= 1'b1; err_code <= 3'd4; sd_cs <= 1'b1;
              end
            endcase
          end else if (cnt_nxt == CNT_W'(RESP_TIMEOUT)) begin
            state <= ST_ERROR; error <= 1'b1; err_code <= r1_err(cmd_sel); sd_cs <= 1'b1;
          end else begin
            cnt  <= cnt_nxt;
            want <= 1'b1;
          end
        end

        // Trailing 4 bytes of R7; only the check pattern in the last one matters.
        ST_R7: if (done_ev) begin
          if (cnt_nxt == CNT_W'(4)) begin
            if (spi_rx == 8'hAA) begin
              sd_cs <= 1'b1; spi_tx <= 8'hFF; want <= 1'b1;
              state <= ST_GAP; gap_idle <= 1'b0; cmd_sel <= C_CMD55;
            end else begin
              state <= ST_ERROR; error <= 1'b1; err_code <= 3'd2; sd_cs <= 1'b1;
            end
          end else begin
            cnt  <= cnt_nxt;
            want <= 1'b1;
          end
        end

        ST_GAP: if (done_ev) begin
          if (gap_idle) begin
            state <= ST_IDLE;
            ready <= 1'b1;
          end else begin
            state <= ST_CMD;
          end
        end

        ST_IDLE: if (ready && rd_req) begin
          ready   <= 1'b0;
          addr_q  <= rd_addr;
          cmd_sel <= C_CMD17;
          state   <= ST_CMD;
        end

        ST_TOKEN: if (done_ev) begin
          if (spi_rx == 8'hFE) begin
            spi_tx   <= 8'hFF;
            want     <= 1'b1;
            data_cnt <= '0;
            state    <= ST_DATA;
          end else if (spi_rx != 8'hFF || cnt_nxt == CNT_W'(TOKEN_TIMEOUT)) begin
            state <= ST_ERROR; error <= 1'b1; err_code <= 3'd5; sd_cs <= 1'b1;
          end else begin
            cnt  <= cnt_nxt;
            want <= 1'b1;
          end
        end

        ST_DATA: if (done_ev) begin
          rd_data  <= spi_rx;
          rd_valid <= 1'b1;
          rd_last  <= (data_cnt == DCNT_W'(511));
          spi_tx   <= 8'hFF;
          want     <= 1'b1;
          if (data_cnt == DCNT_W'(511)) begin
            cnt   <= '0;
            state <= ST_CRC;
          end else begin
            data_cnt <= data_cnt + DCNT_W'(1);
          end
        end

        ST_CRC: if (done_ev) begin
          if (cnt_nxt == CNT_W'(2)) begin
            sd_cs <= 1'b1; spi_tx <= 8'hFF; want <= 1'b1;
            state <= ST_GAP; gap_idle <= 1'b1;
          end else begin
            cnt  <= cnt_nxt;
            want <= 1'b1;
          end
        end

        // Parked until reset: no bytes queued, card deselected.
        ST_ERROR: begin
          want  <= 1'b0;
          sd_cs <= 1'b1;
          error <= 1'b1;
        end

        default: state <= ST_ERROR;
      endcase
    end
  end

endmodule

// File: tb/tb_sd_cmd_seq.sv
// Directed bench for sd_cmd_seq with a behavioural SPI master and SD card.
module tb_sd_cmd_seq;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        rd_req = 1'b0;
  logic [31:0] rd_addr = 32'h0;
  logic        ready, init_done, error, rd_valid, rd_last, spi_start, sd_cs;
  logic [2:0]  err_code;
  logic [7:0]  rd_data, spi_tx;
  logic [7:0]  spi_rx = 8'hFF;
  logic        spi_done = 1'b0;
  logic        spi_busy = 1'b0;

  sd_cmd_seq #(
    .INIT_BYTES(10), .RESP_TIMEOUT(8), .TOKEN_TIMEOUT(1024), .INIT_RETRIES(4)
  ) dut (
    .clk(clk), .reset(reset), .rd_req(rd_req), .rd_addr(rd_addr),
    .ready(ready), .init_done(init_done), .error(error), .err_code(err_code),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_last(rd_last),
    .spi_start(spi_start), .spi_tx(spi_tx), .spi_rx(spi_rx),
    .spi_done(spi_done), .spi_busy(spi_busy), .sd_cs(sd_cs)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // Card behaviour knobs.
  logic cmd0_dead = 1'b0;
  logic token_bad = 1'b0;
  int   a41_busy  = 2;

  // Monitor / model state, all owned by the negedge process.
  int nvalid = 0, nstart = 0, first_valid_start = 0, start_at_last = 0;
  int data_bad = 0, last_bad = 0, overlap_bad = 0;
  int n0 = 0, n55 = 0, n41 = 0, n17 = 0;
  int cs_run = 0, frame_run = 0, flen = 0, busy_cnt = 0;
  logic [47:0] fbuf = 48'h0;
  logic [47:0] fr_log [64];
  int          run_log [64];
  logic [7:0]  rx_hold = 8'hFF;
  logic [7:0]  rq [$];

  task automatic respond(input logic [5:0] idx);
    case (idx)
      6'd0: begin
        n0++;
        if (!cmd0_dead) begin rq.push_back(8'hFF); rq.push_back(8'h01); end
      end
      6'd8: begin
        rq.push_back(8'hFF); rq.push_back(8'h01); rq.push_back(8'h00);
        rq.push_back(8'h00); rq.push_back(8'h01); rq.push_back(8'hAA);
      end
      6'd55: begin n55++; rq.push_back(8'hFF); rq.push_back(8'h01); end
      6'd41: begin
        n41++;
        rq.push_back(8'hFF);
        rq.push_back((n41 > a41_busy) ? 8'h00 : 8'h01);
      end
      6'd17: begin
        n17++;
        rq.push_back(8'hFF); rq.push_back(8'h00);
        if (token_bad) rq.push_back(8'h05);
        else begin
          rq.push_back(8'hFF); rq.push_back(8'hFF); rq.push_back(8'hFE);
          for (int i = 0; i < 512; i++) rq.push_back(8'(i));
          rq.push_back(8'h12); rq.push_back(8'h34);
        end
      end
      default: begin rq.push_back(8'hFF); rq.push_back(8'h04); end
    endcase
  endtask

  task automatic card_byte(input logic [7:0] tx, input logic cs, output logic [7:0] rx);
    rx = 8'hFF;
    if (cs) begin
      cs_run++;
      flen = 0;
      rq.delete();
    end else if (rq.size() != 0) begin
      rx = rq.pop_front();
      cs_run = 0;
    end else begin
      if (flen != 0 || tx != 8'hFF) begin
        if (flen == 0) frame_run = cs_run;
        fbuf = {fbuf[39:0], tx};
        flen++;
        if (flen == 6) begin
          flen = 0;
          fr_log[fbuf[45:40]] = fbuf;
          run_log[fbuf[45:40]] = frame_run;
          respond(fbuf[45:40]);
        end
      end
      cs_run = 0;
    end
  endtask

  // SPI master model (3-cycle byte time) plus output monitors.
  always @(negedge clk) begin
    if (reset === 1'b0) begin
      nvalid = 0; nstart = 0; n0 = 0; n55 = 0; n41 = 0; n17 = 0;
      for (int i = 0; i < 64; i++) begin fr_log[i] = 48'h0; run_log[i] = 0; end
    end
    if (rd_valid === 1'b1) begin
      if (nvalid == 0) first_valid_start = nstart;
      if (rd_data !== 8'(nvalid)) data_bad++;
      if ((rd_last === 1'b1) != ((nvalid % 512) == 511)) last_bad++;
      if (rd_last === 1'b1) start_at_last = nstart;
      nvalid++;
    end else if (rd_last === 1'b1) last_bad++;
    if (spi_start === 1'b1) begin
      nstart++;
      if (spi_busy || spi_done) overlap_bad++;
    end
    if (spi_done) begin
      spi_done = 1'b0;
      spi_busy = 1'b0;
    end else if (busy_cnt != 0) begin
      busy_cnt--;
      if (busy_cnt == 0) begin spi_done = 1'b1; spi_rx = rx_hold; end
    end
    if (spi_start === 1'b1 && !spi_busy) begin
      card_byte(spi_tx, sd_cs, rx_hold);
      spi_busy = 1'b1;
      busy_cnt = 3;
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic wait_ready(input int maxc);
    for (int i = 0; i < maxc; i++) begin
      if (ready === 1'b1) break;
      @(negedge clk);
    end
  endtask

  task automatic wait_error(input int maxc);
    for (int i = 0; i < maxc; i++) begin
      if (error === 1'b1) break;
      @(negedge clk);
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk); #1 reset = 1'b0;
    @(negedge clk); #1 reset = 1'b1;
  endtask

  task automatic pulse_rd(input logic [31:0] a);
    @(negedge clk); #1 rd_addr = a; rd_req = 1'b1;
    @(negedge clk); #1 rd_req = 1'b0;
  endtask

  initial begin
    int base;
    int nv;

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_spi_start", 64'(spi_start), 64'd0);
    chk("rst_spi_tx",    64'(spi_tx),    64'hFF);
    chk("rst_sd_cs",     64'(sd_cs),     64'd1);
    chk("rst_ready",     64'(ready),     64'd0);
    chk("rst_init_done", 64'(init_done), 64'd0);
    chk("rst_error",     64'(error),     64'd0);
    chk("rst_err_code",  64'(err_code),  64'd0);
    chk("rst_rd_data",   64'(rd_data),   64'd0);
    chk("rst_rd_valid",  64'(rd_valid),  64'd0);
    chk("rst_rd_last",   64'(rd_last),   64'd0);
    #1 reset = 1'b1;

    // Normal init: ACMD41 busy twice, then ready
    wait_ready(4000);
    chk("init_ready",     64'(ready),     64'd1);
    chk("init_done",      64'(init_done), 64'd1);
    chk("init_error",     64'(error),     64'd0);
    chk("init_sd_cs",     64'(sd_cs),     64'd1);
    chk("cmd0_frame",     64'(fr_log[0]),  64'h40_0000_0000_95);
    chk("pwrup_cs_bytes", 64'(run_log[0]), 64'd10);
    chk("cmd8_frame",     64'(fr_log[8]),  64'h48_0000_01AA_87);
    chk("cmd55_frame",    64'(fr_log[55]), 64'h77_0000_0000_01);
    chk("acmd41_frame",   64'(fr_log[41]), 64'h69_4000_0000_01);
    chk("n_cmd55",        64'(n55), 64'd3);
    chk("n_acmd41",       64'(n41), 64'd3);

    // Block read of address 0x10
    @(negedge clk);
    base = nstart;
    @(negedge clk); #1 rd_addr = 32'h0000_0010; rd_req = 1'b1;
    @(negedge clk);
    chk("rd_ready_drop", 64'(ready), 64'd0);
    #1 rd_req = 1'b0;
    wait_ready(6000);
    chk("rd_ready_back",  64'(ready), 64'd1);
    chk("cmd17_frame",    64'(fr_log[17]), 64'h51_0000_0010_01);
    chk("rd_count",       64'(nvalid), 64'd512);
    chk("rd_data_bad",    64'(data_bad), 64'd0);
    chk("rd_last_bad",    64'(last_bad), 64'd0);
    chk("rd_latency",     64'(first_valid_start - base), 64'd12);
    chk("rd_tail_bytes",  64'(nstart - start_at_last), 64'd3);
    chk("rd_error",       64'(error), 64'd0);

    // Reset for one cycle during data byte 100 of a second read
    pulse_rd(32'h0000_0055);
    for (int i = 0; i < 6000; i++) begin
      if (nvalid >= 612) break;
      @(negedge clk);
    end
    chk("mid_reached", 64'(nvalid >= 612), 64'd1);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("mid_spi_start", 64'(spi_start), 64'd0);
    chk("mid_spi_tx",    64'(spi_tx),    64'hFF);
    chk("mid_sd_cs",     64'(sd_cs),     64'd1);
    chk("mid_ready",     64'(ready),     64'd0);
    chk("mid_init_done", 64'(init_done), 64'd0);
    chk("mid_rd_valid",  64'(rd_valid),  64'd0);
    chk("mid_rd_data",   64'(rd_data),   64'd0);
    #1 reset = 1'b1;
    wait_ready(4000);
    chk("mid_reinit_ready", 64'(ready), 64'd1);
    chk("mid_no_valid",     64'(nvalid), 64'd0);
    chk("mid_cs_bytes",     64'(run_log[0]), 64'd10);
    chk("mid_cmd0_frame",   64'(fr_log[0]), 64'h40_0000_0000_95);
    chk("mid_init_done2",   64'(init_done), 64'd1);

    // Bad data token after CMD17
    token_bad = 1'b1;
    pulse_rd(32'h0000_0020);
    wait_error(3000);
    chk("tok_error",    64'(error), 64'd1);
    chk("tok_err_code", 64'(err_code), 64'd5);
    chk("tok_no_valid", 64'(nvalid), 64'd0);
    chk("tok_sd_cs",    64'(sd_cs), 64'd1);
    nv = nstart;
    pulse_rd(32'h0000_0030);
    repeat (60) @(negedge clk);
    chk("err_no_start", 64'(nstart), 64'(nv));
    chk("err_n_cmd17",  64'(n17), 64'd1);
    chk("err_ready",    64'(ready), 64'd0);

    // ACMD41 never leaves idle: give up after INIT_RETRIES pairs
    token_bad = 1'b0;
    a41_busy  = 1000;
    pulse_reset();
    wait_error(4000);
    chk("rty_error",     64'(error), 64'd1);
    chk("rty_err_code",  64'(err_code), 64'd3);
    chk("rty_n_acmd41",  64'(n41), 64'd4);
    chk("rty_n_cmd55",   64'(n55), 64'd4);
    chk("rty_init_done", 64'(init_done), 64'd0);

    // CMD0 never answered: timeout after 8 polls, then silence
    cmd0_dead = 1'b1;
    pulse_reset();
    wait_error(2000);
    repeat (40) @(negedge clk);
    chk("c0_error",    64'(error), 64'd1);
    chk("c0_err_code", 64'(err_code), 64'd1);
    chk("c0_sd_cs",    64'(sd_cs), 64'd1);
    chk("c0_starts",   64'(nstart), 64'd24);
    chk("c0_n_cmd0",   64'(n0), 64'd1);

    chk("start_overlap", 64'(overlap_bad), 64'd0);
    chk("data_bad_all",  64'(data_bad), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
